// File: rtl/wb_sram_pkg.sv
// Shared Wishbone SRAM definitions: responder state encoding and bus width constants.
package wb_defs;

  localparam int WB_DW = 32;
  localparam int WB_SW = 2;
  localparam int WB_LW = WB_DW / WB_SW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_sram_mem.sv
// Halfword-lane SRAM array for wb_sram: per-lane write enables and a registered read port.
module wb_sram_mem
  import wb_defs::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WB_SW-1:0]  we_i,
  input  logic [WB_DW-1:0]  wdat_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  output logic [WB_DW-1:0]  rdat_o
);

  logic [WB_LW-1:0] lane_hi [DEPTH_WORDS];
  logic [WB_LW-1:0] lane_lo [DEPTH_WORDS];
  logic [WB_DW-1:0] rdat_q, rdat_d;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (we_i[1]) lane_hi[addr_i] <= wdat_i[WB_DW-1:WB_LW];
    if (we_i[0]) lane_lo[addr_i] <= wdat_i[WB_LW-1:0];
  end

  always_comb begin
    rdat_d = rdat_q;
    if (rd_en_i) rdat_d = rd_clr_i ? '0 : {lane_hi[addr_i], lane_lo[addr_i]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdat_q <= '0;
    else       rdat_q <= rdat_d;
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/wb_sram.sv
// Wishbone classic-cycle SRAM responder with programmable wait states.
// Optional out-of-range error termination when WB_SRAM_ERR_EN is defined.
module wb_sram
  import wb_defs::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [WB_DW-1:0]  wb_dat_i,
  output logic [WB_DW-1:0]  wb_dat_o,
  input  logic [WB_SW-1:0]  wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              wb_err_o
);

  // state | meaning
  // IDLE  | waiting for cyc&stb; request fields latched on accept
  // WAIT  | counting down wait states; cyc drop aborts silently
  // RESP  | one-cycle ack/err, read data valid, write commits on exit edge

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic             we_q, we_d;
  logic [WB_SW-1:0] sel_q, sel_d;
  logic [WB_DW-1:0] wdat_q, wdat_d;
  logic             err_q, err_d;
  logic             addr_err;
  logic             adr_unused;
  logic [AW-1:0]    mem_addr;
  logic [WB_SW-1:0] mem_we;
  logic             mem_rd_en;

  assign adr_unused = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

`ifdef WB_SRAM_ERR_EN
  assign addr_err = ({1'b0, wb_adr_i} >= (33'(DEPTH_WORDS) * 33'd4));
`else
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i[AW+1:2];
          we_d    = wb_we_i;
          sel_d   = wb_sel_i;
          wdat_d  = wb_dat_i;
          err_d   = addr_err;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!wb_cyc_i)           state_d = IDLE;
        else if (cnt_q == 4'd0)  state_d = RESP;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      err_q   <= err_d;
    end
  end

  // Read on the edge entering RESP (live address when coming straight from IDLE),
  // write on the edge leaving RESP, so the two never share an edge.
  assign mem_addr  = (state_q == IDLE) ? wb_adr_i[AW+1:2] : adr_q;
  assign mem_rd_en = !rst_i && (state_q != RESP) && (state_d == RESP);
  assign mem_we    = (state_q == RESP && we_q && !err_q && !rst_i) ? sel_q : '0;

  wb_sram_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (mem_addr),
    .we_i     (mem_we),
    .wdat_i   (wdat_q),
    .rd_en_i  (mem_rd_en),
    .rd_clr_i (err_d),
    .rdat_o   (wb_dat_o)
  );

`ifdef WB_SRAM_ERR_EN
  assign wb_ack_o = (state_q == RESP) && !err_q;
  assign wb_err_o = (state_q == RESP) && err_q;
`else
  assign wb_ack_o = (state_q == RESP);
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sram.sv
// Directed bench for wb_sram: three instances (WAIT_STATES 0, 2, 3) sharing clock and reset.
module tb_wb_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr   [3];
  logic [31:0] dat_i [3];
  logic [31:0] dat_o [3];
  logic [1:0]  sel   [3];
  logic        we    [3];
  logic        cyc   [3];
  logic        stb   [3];
  logic        ack   [3];
  logic        err   [3];

  int ws_of [3] = '{0, 2, 3};
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_sram #(
      .DEPTH_WORDS (1024),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .wb_adr_i (adr[g]),
      .wb_dat_i (dat_i[g]),
      .wb_dat_o (dat_o[g]),
      .wb_sel_i (sel[g]),
      .wb_we_i  (we[g]),
      .wb_cyc_i (cyc[g]),
      .wb_stb_i (stb[g]),
      .wb_ack_o (ack[g]),
      .wb_err_o (err[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int m = 0; m < 3; m++) chk($sformatf("ack_err_exclusive[%0d]", m), 32'(ack[m] & err[m]), 32'd0);
    end
  end

  task automatic bus_idle(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic bus_req(input int d, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] s);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_i[d] = wd; sel[d] = s;
  endtask

  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] s, input bit chk_dat, input bit exp_err,
                      input logic [31:0] exp_dat, input string name);
    int  k;
    bit  got;
    logic [31:0] held;
    @(negedge clk);
    bus_req(d, w, a, wd, s);
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (ack[d] || err[d]) got = 1'b1;
    end
    chk({name, "_term_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, k, ws_of[d] + 1);
    chk({name, "_ack"}, 32'(ack[d]), 32'(!exp_err));
    chk({name, "_err"}, 32'(err[d]), 32'(exp_err));
    if (chk_dat) chk({name, "_data"}, dat_o[d], exp_dat);
    held = dat_o[d];
    bus_idle(d);
    @(negedge clk);
    chk({name, "_one_cycle"}, {30'd0, ack[d], err[d]}, 32'd0);
    chk({name, "_hold"}, dat_o[d], held);
  endtask

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  s;
    bit          chk_dat;
    bit          exp_err;
    logic [31:0] exp_dat;
    string       name;
  } vec_t;

  vec_t vecs [15];
  logic [31:0] b2b_adr [3] = '{32'h10, 32'h14, 32'h0};
  logic [31:0] b2b_exp [3] = '{32'hDEADBEEF, 32'h1234AAAA, 32'hA5A55A5A};

  initial begin
    vecs[0]  = '{0, 1'b1, 32'h10,   32'hDEADBEEF, 2'b11, 1'b0, 1'b0, 32'h0,        "ws0_wr_10"};
    vecs[1]  = '{0, 1'b0, 32'h10,   32'h0,        2'b11, 1'b1, 1'b0, 32'hDEADBEEF, "ws0_rd_10"};
    vecs[2]  = '{1, 1'b1, 32'h20,   32'h11112222, 2'b11, 1'b0, 1'b0, 32'h0,        "ws2_pre_20"};
    vecs[3]  = '{1, 1'b1, 32'h20,   32'hAAAABBBB, 2'b10, 1'b1, 1'b0, 32'h11112222, "ws2_wr_hi_20"};
    vecs[4]  = '{1, 1'b0, 32'h20,   32'h0,        2'b00, 1'b1, 1'b0, 32'hAAAA2222, "ws2_rd_20"};
    vecs[5]  = '{0, 1'b1, 32'h14,   32'h12345678, 2'b11, 1'b0, 1'b0, 32'h0,        "ws0_wr_14"};
    vecs[6]  = '{0, 1'b1, 32'h16,   32'h9999AAAA, 2'b01, 1'b1, 1'b0, 32'h12345678, "ws0_wr_lo_16"};
    vecs[7]  = '{0, 1'b0, 32'h17,   32'h0,        2'b01, 1'b1, 1'b0, 32'h1234AAAA, "ws0_rd_17"};
    vecs[8]  = '{0, 1'b1, 32'h14,   32'hFFFFFFFF, 2'b00, 1'b1, 1'b0, 32'h1234AAAA, "ws0_wr_sel00"};
    vecs[9]  = '{0, 1'b0, 32'h14,   32'h0,        2'b11, 1'b1, 1'b0, 32'h1234AAAA, "ws0_rd_14"};
    vecs[10] = '{2, 1'b1, 32'h30,   32'h0BADF00D, 2'b11, 1'b0, 1'b0, 32'h0,        "ws3_wr_30"};
    vecs[11] = '{2, 1'b0, 32'h30,   32'h0,        2'b11, 1'b1, 1'b0, 32'h0BADF00D, "ws3_rd_30"};
    vecs[12] = '{0, 1'b1, 32'h0,    32'hA5A55A5A, 2'b11, 1'b0, 1'b0, 32'h0,        "ws0_wr_0"};
    vecs[13] = '{2, 1'b1, 32'h40,   32'h77778888, 2'b11, 1'b0, 1'b0, 32'h0,        "ws3_wr_40"};
`ifdef WB_SRAM_ERR_EN
    vecs[14] = '{0, 1'b0, 32'h1000, 32'h0,        2'b11, 1'b1, 1'b1, 32'h0,        "ws0_rd_oob_err"};
`else
    vecs[14] = '{0, 1'b0, 32'h1000, 32'h0,        2'b11, 1'b1, 1'b0, 32'hA5A55A5A, "ws0_rd_wrap"};
`endif

    for (int i = 0; i < 3; i++) begin
      bus_idle(i); adr[i] = '0; dat_i[i] = '0; sel[i] = '0;
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ack_err[%0d]", i), {30'd0, ack[i], err[i]}, 32'd0);
      chk($sformatf("reset_dat[%0d]", i), dat_o[i], 32'd0);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 15; i++)
      xfer(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s,
           vecs[i].chk_dat, vecs[i].exp_err, vecs[i].exp_dat, vecs[i].name);

    // Abort: cyc dropped one cycle after a WAIT_STATES=3 write is accepted
    @(negedge clk);
    bus_req(2, 1'b1, 32'h30, 32'hFFFF0000, 2'b11);
    @(negedge clk);
    bus_idle(2);
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_term", {30'd0, ack[2], err[2]}, 32'd0);
    end
    xfer(2, 1'b0, 32'h30, 32'h0, 2'b11, 1'b1, 1'b0, 32'h0BADF00D, "abort_rd_30");

    // Reset pulsed while a write to 0x40 sits in WAIT
    @(negedge clk);
    bus_req(2, 1'b1, 32'h40, 32'h12121212, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    bus_idle(2);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_term", {30'd0, ack[2], err[2]}, 32'd0);
    chk("rst_wait_dat", dat_o[2], 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("rst_wait_no_term", {30'd0, ack[2], err[2]}, 32'd0);
    end
    xfer(2, 1'b0, 32'h40, 32'h0, 2'b11, 1'b1, 1'b0, 32'h77778888, "rst_rd_40");

    // Back-to-back reads with cyc/stb held high
    @(negedge clk);
    bus_req(0, 1'b0, b2b_adr[0], 32'h0, 2'b11);
    for (int i = 0; i < 3; i++) begin
      int  k;
      bit  got;
      k = 0; got = 1'b0;
      while (!got && k < 20) begin
        @(negedge clk);
        k++;
        if (ack[0]) got = 1'b1;
      end
      chk($sformatf("b2b_ack_seen[%0d]", i), 32'(got), 32'd1);
      chk($sformatf("b2b_data[%0d]", i), dat_o[0], b2b_exp[i]);
      if (i < 2) adr[0] = b2b_adr[i+1];
      else       bus_idle(0);
      @(negedge clk);
      chk($sformatf("b2b_gap[%0d]", i), 32'(ack[0]), 32'd0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_sram.md
WB_SRAM -- requirements
Module: wb_sram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words, power of two.
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra cycles inserted before acknowledge (0..15).
REQ-003 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: wb_adr_i  in  32  byte address from master.
REQ-006 SHALL have ports: wb_dat_i  in  32  write data.
REQ-007 SHALL have ports: wb_dat_o  out  32  read data.
REQ-008 SHALL have ports: wb_sel_i  in  2  halfword lane select; bit1 = [31:16], bit0 = [15:0].
REQ-009 SHALL have ports: wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  write enable, cycle, strobe.
REQ-010 SHALL have ports: wb_ack_o  out  1  normal termination; wb_err_o  out  1  error termination.

Function
REQ-011 SHALL be a Wishbone classic-cycle responder; request accepted when wb_cyc_i & wb_stb_i high in state IDLE.
REQ-012 SHALL use states IDLE, WAIT, RESP; IDLE->WAIT on accept if WAIT_STATES>0, else IDLE->RESP.
REQ-013 SHALL load a wait counter with WAIT_STATES-1 on accept; WAIT decrements; WAIT->RESP when counter = 0.
REQ-014 SHALL assert wb_ack_o (or wb_err_o) for exactly one cycle in RESP; RESP->IDLE unconditionally.
REQ-015 SHALL give latency WAIT_STATES+1 cycles from accepting edge to ack-high cycle.
REQ-016 SHALL not accept a new request in the RESP cycle; earliest back-to-back accept is the cycle after ack.
REQ-017 SHALL latch address, we, sel and write data at accept; later master changes SHALL be ignored.
REQ-018 SHALL index storage with latched adr[log2(DEPTH_WORDS)+1:2]; adr[1:0] ignored.
REQ-019 SHALL commit writes on the RESP edge, only halves with sel bit set; sel=2'b00 write acks with no change.
REQ-020 SHALL drive wb_dat_o with full addressed word in RESP cycle regardless of sel; hold last value otherwise.
REQ-021 SHALL abort to IDLE without write and without ack if wb_cyc_i drops during WAIT.
REQ-022 SHALL never assert wb_ack_o and wb_err_o in the same cycle.

Reset
REQ-023 SHALL on rst_i go to IDLE, clear wait counter, drive wb_ack_o=0, wb_err_o=0, wb_dat_o=0 the following cycle.
REQ-024 SHALL discard any in-flight transaction on reset (no write, no ack); storage contents not cleared.

Configuration
REQ-025 SHALL, with WB_SRAM_ERR_EN defined, terminate accesses with adr >= DEPTH_WORDS*4 by wb_err_o, no write, wb_dat_o=0.
REQ-026 SHALL, without WB_SRAM_ERR_EN, ignore upper address bits (wrap modulo depth) and tie wb_err_o to 0.

Structure
REQ-027 SHALL place state encodings (IDLE/WAIT/RESP) and Wishbone data/select width constants in shared package wb_defs.
REQ-028 SHALL contain one sub-module wb_sram_mem: two 16-bit lane arrays, per-lane write enable, registered read.

Verification
REQ-029 SHALL cover: WAIT_STATES=0, write 0xDEADBEEF to 0x10 sel=11, read 0x10 -> ack 1 cycle after accept each, read data 0xDEADBEEF.
REQ-030 SHALL cover: WAIT_STATES=2, preload 0x11112222 at 0x20, write 0xAAAABBBB sel=10 -> ack 3 cycles after accept; readback 0xAAAA2222.
REQ-031 SHALL cover: WAIT_STATES=3, cyc dropped 1 cycle after accept of write to 0x30 -> no ack; readback unchanged.
REQ-032 SHALL cover: WB_SRAM_ERR_EN, DEPTH_WORDS=1024, read 0x1000 -> wb_err_o 1 cycle, wb_ack_o 0, dat 0; without macro -> ack, data of word 0.
REQ-033 SHALL cover: rst_i pulsed during WAIT of write 0x40 -> ack/err stay 0, IDLE next cycle, word 0x40 unchanged.
REQ-034 SHALL cover: back-to-back reads with stb held high -> ack pulses separated by at least one low cycle, correct data each.
